// File: rtl/dspl_scan_drv_if.sv
// Digit/blink inputs and multiplexed 7-segment outputs of the
// stopwatch display scan driver.
interface dspl_scan_drv_if;
  logic [5:0] d1;
  logic [5:0] d2;
  logic [5:0] d3;
  logic [5:0] d4;
  logic [5:0] d5;
  logic [5:0] d6;
  logic [5:0] d7;
  logic [5:0] d8;
  logic [7:0] blink_mask;
  logic [7:0] an;
  logic [7:0] dec_cat;
  logic       frame_start;

  modport master (
    output d1, d2, d3, d4, d5, d6, d7, d8,
    output blink_mask,
    input  an, dec_cat, frame_start
  );

  modport slave (
    input  d1, d2, d3, d4, d5, d6, d7, d8,
    input  blink_mask,
    output an, dec_cat, frame_start
  );
endinterface

// File: rtl/dspl_scan_drv.sv
// Eight-digit common-anode 7-segment scan driver with per-frame
// shadow latch, BCD decode, per-digit blanking and blink.
module dspl_scan_drv #(
  parameter int unsigned BASE_CLOCK   = 100_000_000,
  parameter int unsigned REFRESH_HZ   = 1000,
  parameter int unsigned BLINK_FRAMES = 250,
  parameter bit          SIMULATION   = 1'b0
) (
  input  logic            clock,
  input  logic            reset,
  dspl_scan_drv_if.slave  bus
);
  localparam int unsigned DIV =
    SIMULATION ? 4 : BASE_CLOCK / (8 * REFRESH_HZ);
  localparam int unsigned CW = $clog2(DIV);
  localparam int unsigned FW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic              phase_q, phase_d;
  logic [7:0][5:0]   shadow_q, shadow_d;
  logic [7:0]        mask_q, mask_d;
  logic [7:0]        an_q, an_d;
  logic [7:0]        cat_q, cat_d;
  logic              fs_q, fs_d;
  logic              tick;
  logic              latch;
  logic [5:0]        sel;
  logic              blank;
  logic [7:0]        seg;

  always_comb begin
    tick     = (cnt_q == CW'(DIV - 1));
    latch    = tick && (idx_q == 3'd7);
    cnt_d    = tick ? '0 : cnt_q + CW'(1);
    idx_d    = tick ? idx_q + 3'd1 : idx_q;
    shadow_d = shadow_q;
    mask_d   = mask_q;
    fcnt_d   = fcnt_q;
    phase_d  = phase_q;
    fs_d     = latch;
    if (latch) begin
      shadow_d = {bus.d8, bus.d7, bus.d6, bus.d5,
                  bus.d4, bus.d3, bus.d2, bus.d1};
      mask_d   = bus.blink_mask;
      if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d  = fcnt_q + FW'(1);
      end
    end

    sel   = shadow_q[idx_q];
    blank = !sel[5] || (mask_q[idx_q] && phase_q);
    // Table holds dp-off codes; bit 0 is replaced by the live dp.
    case (sel[4:1])
      4'd0:    seg = 8'h03;
      4'd1:    seg = 8'h9F;
      4'd2:    seg = 8'h25;
      4'd3:    seg = 8'h0D;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h49;
      4'd6:    seg = 8'h41;
      4'd7:    seg = 8'h1F;
      4'd8:    seg = 8'h01;
      4'd9:    seg = 8'h09;
      default: seg = 8'hFD;
    endcase
    an_d  = blank ? 8'hFF : ~(8'b1 << idx_q);
    cat_d = blank ? 8'hFF : {seg[7:1], ~sel[0]};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      fcnt_q   <= '0;
      phase_q  <= 1'b0;
      shadow_q <= '0;
      mask_q   <= '0;
      an_q     <= 8'hFF;
      cat_q    <= 8'hFF;
      fs_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      fcnt_q   <= fcnt_d;
      phase_q  <= phase_d;
      shadow_q <= shadow_d;
      mask_q   <= mask_d;
      an_q     <= an_d;
      cat_q    <= cat_d;
      fs_q     <= fs_d;
    end
  end

  assign bus.an          = an_q;
  assign bus.dec_cat     = cat_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_dspl_scan_drv.sv
// Directed bench for dspl_scan_drv with SIMULATION=1 (DIV=4)
// and BLINK_FRAMES=2.
module tb_dspl_scan_drv;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  dspl_scan_drv_if bus();

  dspl_scan_drv #(
    .BASE_CLOCK   (100_000_000),
    .REFRESH_HZ   (1000),
    .BLINK_FRAMES (2),
    .SIMULATION   (1'b1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset) begin
      checks++;
      if (!$onehot0(~bus.an)) begin
        failures++;
        $display("FAIL anode_onehot an=%h", bus.an);
      end
    end
  end

  task automatic drive(input logic [5:0] d [8], input logic [7:0] m);
    bus.d1 = d[0]; bus.d2 = d[1]; bus.d3 = d[2]; bus.d4 = d[3];
    bus.d5 = d[4]; bus.d6 = d[5]; bus.d7 = d[6]; bus.d8 = d[7];
    bus.blink_mask = m;
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    while (n < 200) begin
      @(negedge clock);
      n++;
      if (bus.frame_start) return;
    end
    n = -1;
  endtask

  // Called at the negedge where frame_start is seen; ends at +30.
  task automatic capture(output logic [7:0] a [8],
                         output logic [7:0] c [8]);
    for (int k = 0; k < 8; k++) begin
      repeat ((k == 0) ? 2 : 4) @(negedge clock);
      a[k] = bus.an;
      c[k] = bus.dec_cat;
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.d1 = 6'($urandom); bus.d2 = 6'($urandom);
      bus.d3 = 6'($urandom); bus.d4 = 6'($urandom);
      bus.d5 = 6'($urandom); bus.d6 = 6'($urandom);
      bus.d7 = 6'($urandom); bus.d8 = 6'($urandom);
      bus.blink_mask = 8'($urandom);
      @(negedge clock);
      checks++;
      if (bus.an !== 8'hFF || bus.dec_cat !== 8'hFF ||
          bus.frame_start !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold an=%h cat=%h fs=%b want FF FF 0",
                 bus.an, bus.dec_cat, bus.frame_start);
      end
    end
  endtask

  task automatic test_first_frame();
    logic [5:0] d [8];
    logic [7:0] a [8];
    logic [7:0] c [8];
    int n;
    d = '{6'h20, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    drive(d, 8'h00);
    @(negedge clock);
    reset = 1'b1;
    wait_fs(n);
    checks++;
    if (n != 32) begin
      failures++;
      $display("FAIL first_fs_latency got=%0d want=32", n);
    end
    checks++;
    if (bus.an !== 8'hFF) begin
      failures++;
      $display("FAIL dark_before_frame an=%h want FF", bus.an);
    end
    capture(a, c);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (a[k] !== ((k == 0) ? 8'hFE : 8'hFF) ||
          c[k] !== ((k == 0) ? 8'h03 : 8'hFF)) begin
        failures++;
        $display("FAIL first_frame slot%0d an=%h cat=%h", k, a[k], c[k]);
      end
    end
  endtask

  task automatic test_decode();
    logic [5:0] d [8];
    logic [7:0] a [8];
    logic [7:0] c [8];
    logic [7:0] ea [8];
    logic [7:0] ec [8];
    int n;
    d  = '{6'h20, 6'h00, 6'h38, 6'h00, 6'h00, 6'h00, 6'h00, 6'h31};
    ea = '{8'hFE, 8'hFF, 8'hFB, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F};
    ec = '{8'h03, 8'hFF, 8'hFD, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    drive(d, 8'h00);
    wait_fs(n);
    capture(a, c);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (a[k] !== ea[k] || c[k] !== ec[k]) begin
        failures++;
        $display("FAIL decode slot%0d an=%h cat=%h want %h %h",
                 k, a[k], c[k], ea[k], ec[k]);
      end
    end
  endtask

  task automatic test_seg_table();
    logic [5:0] d [8];
    logic [7:0] a [8];
    logic [7:0] c [8];
    logic [7:0] ea [8];
    logic [7:0] ec [8];
    int n;
    d  = '{6'h22, 6'h24, 6'h26, 6'h28, 6'h2A, 6'h2C, 6'h2E, 6'h32};
    ea = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    ec = '{8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F, 8'h09};
    drive(d, 8'h00);
    wait_fs(n);
    capture(a, c);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (a[k] !== ea[k] || c[k] !== ec[k]) begin
        failures++;
        $display("FAIL seg_digits slot%0d an=%h cat=%h want %h %h",
                 k, a[k], c[k], ea[k], ec[k]);
      end
    end
    d  = '{6'h34, 6'h36, 6'h38, 6'h3A, 6'h3C, 6'h3E, 6'h07, 6'h33};
    ea = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hFF, 8'h7F};
    ec = '{8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFF, 8'h08};
    drive(d, 8'h00);
    wait_fs(n);
    capture(a, c);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (a[k] !== ea[k] || c[k] !== ec[k]) begin
        failures++;
        $display("FAIL seg_dash slot%0d an=%h cat=%h want %h %h",
                 k, a[k], c[k], ea[k], ec[k]);
      end
    end
  endtask

  task automatic test_midframe();
    logic [5:0] d [8];
    int n;
    d = '{6'h20, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    drive(d, 8'h00);
    wait_fs(n);
    @(negedge clock);
    bus.d1 = 6'h22;
    @(negedge clock);
    checks++;
    if (bus.an !== 8'hFE || bus.dec_cat !== 8'h03) begin
      failures++;
      $display("FAIL midframe_hold an=%h cat=%h want FE 03",
               bus.an, bus.dec_cat);
    end
    wait_fs(n);
    checks++;
    if (n != 30) begin
      failures++;
      $display("FAIL frame_period got=%0d want=30", n);
    end
    repeat (2) @(negedge clock);
    checks++;
    if (bus.an !== 8'hFE || bus.dec_cat !== 8'h9F) begin
      failures++;
      $display("FAIL midframe_new an=%h cat=%h want FE 9F",
               bus.an, bus.dec_cat);
    end
  endtask

  task automatic test_blink();
    logic [5:0] d [8];
    logic [7:0] ea [6];
    logic [7:0] ec [6];
    int n;
    ea = '{8'hFE, 8'hFF, 8'hFF, 8'hFE, 8'hFE, 8'hFF};
    ec = '{8'h9F, 8'hFF, 8'hFF, 8'h9F, 8'h9F, 8'hFF};
    @(negedge clock);
    reset = 1'b0;
    d = '{6'h22, 6'h24, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    drive(d, 8'h01);
    @(negedge clock);
    reset = 1'b1;
    for (int f = 0; f < 6; f++) begin
      wait_fs(n);
      repeat (2) @(negedge clock);
      checks++;
      if (bus.an !== ea[f] || bus.dec_cat !== ec[f]) begin
        failures++;
        $display("FAIL blink_slot0 frame%0d an=%h cat=%h want %h %h",
                 f, bus.an, bus.dec_cat, ea[f], ec[f]);
      end
      repeat (4) @(negedge clock);
      checks++;
      if (bus.an !== 8'hFD || bus.dec_cat !== 8'h25) begin
        failures++;
        $display("FAIL blink_unmasked frame%0d an=%h cat=%h want FD 25",
                 f, bus.an, bus.dec_cat);
      end
    end
  endtask

  task automatic test_reset_midscan();
    logic [5:0] d [8];
    int n;
    bit dark;
    d = '{6'h20, 6'h20, 6'h20, 6'h20, 6'h20, 6'h20, 6'h20, 6'h20};
    drive(d, 8'h00);
    wait_fs(n);
    repeat (22) @(negedge clock);
    checks++;
    if (bus.an !== 8'hDF || bus.dec_cat !== 8'h03) begin
      failures++;
      $display("FAIL slot5_before_reset an=%h cat=%h want DF 03",
               bus.an, bus.dec_cat);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.an !== 8'hFF || bus.dec_cat !== 8'hFF ||
        bus.frame_start !== 1'b0) begin
      failures++;
      $display("FAIL async_reset an=%h cat=%h fs=%b want FF FF 0",
               bus.an, bus.dec_cat, bus.frame_start);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    n = 0;
    dark = 1'b1;
    while (n < 200) begin
      @(negedge clock);
      n++;
      if (bus.an !== 8'hFF) dark = 1'b0;
      if (bus.frame_start) break;
    end
    checks++;
    if (n != 32 || !dark) begin
      failures++;
      $display("FAIL restart_frame latency=%0d dark=%b want 32 1", n, dark);
    end
    repeat (2) @(negedge clock);
    checks++;
    if (bus.an !== 8'hFE || bus.dec_cat !== 8'h03) begin
      failures++;
      $display("FAIL restart_slot0 an=%h cat=%h want FE 03",
               bus.an, bus.dec_cat);
    end
  endtask

  initial begin
    bus.d1 = '0; bus.d2 = '0; bus.d3 = '0; bus.d4 = '0;
    bus.d5 = '0; bus.d6 = '0; bus.d7 = '0; bus.d8 = '0;
    bus.blink_mask = '0;
    test_reset();
    test_first_frame();
    test_decode();
    test_seg_table();
    test_midframe();
    test_blink();
    test_reset_midscan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
